// File: rtl/sphere_loader_pkg.sv
// Shared types for the sphere loader.
//   sphere_t       : packed 64-bit sphere record (x, y, z fixed point with 3 fraction bits, r, c)
//   loader_state_e : loader FSM states
//   pack_sphere    : joins the seven buffered record bytes with the final byte
package sphere_loader_pkg;

  localparam int unsigned SPHERE_B        = 64;
  localparam int unsigned MAX_SPHERES_DEF = 8;

  // The first field is the most significant, so the first byte on the wire is x[15:8].
  typedef struct packed {
    logic signed [15:0] x;
    logic signed [14:0] y;
    logic signed [14:0] z;
    logic        [5:0]  r;
    logic        [11:0] c;
  } sphere_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SWAP_WAIT} loader_state_e;

  function automatic sphere_t pack_sphere(input logic [55:0] hi, input logic [7:0] lo);
    return sphere_t'({hi, lo});
  endfunction

endpackage

// File: rtl/sphere_loader_if.sv
// Byte-stream link from the host-link receiver into the sphere loader.
//   in_data  : scene byte
//   in_valid : in_data valid
//   in_ready : loader accepts; a byte transfers when in_valid and in_ready are both high
interface sphere_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/sphere_table_dp.sv
// Double-buffered sphere table: two banks of MaxSpheres records in one RAM.
//   clk_i, rst_i          : clock, synchronous active-high reset (read register only)
//   we_i, wr_bank_i,
//   wr_addr_i, wr_data_i  : write port
//   rd_bank_i, rd_addr_i  : read address, registered into rd_data_o
//   rd_data_o             : record read one cycle after the address is presented
module sphere_table_dp
  import sphere_loader_pkg::*;
#(
  parameter int unsigned MaxSpheres = MAX_SPHERES_DEF,
  parameter int unsigned IdxB       = $clog2(MaxSpheres)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic            wr_bank_i,
  input  logic [IdxB-1:0] wr_addr_i,
  input  sphere_t         wr_data_i,
  input  logic            rd_bank_i,
  input  logic [IdxB-1:0] rd_addr_i,
  output sphere_t         rd_data_o
);

  // Bank select is the top address bit; contents are not reset.
  sphere_t mem_q [2*MaxSpheres];
  sphere_t rd_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem_q[{rd_bank_i, rd_addr_i}];
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/sphere_loader.sv
// Assembles the scene byte stream (header N, then N x 8 bytes MSB first) into sphere
// records, writes them to the back buffer and swaps buffers on the renderer's frame_end.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   in_if            : byte stream (slave side)
//   frame_end_i      : one-cycle pulse after the last pixel of a frame
//   rd_idx_i         : front-buffer entry to read
//   rd_sphere_o      : record at rd_idx_i, one cycle later
//   active_count_o   : number of valid spheres in the front buffer
//   load_busy_o      : high whenever not idle
//   overflow_err_o   : sticky, header count exceeded MaxSpheres
module sphere_loader
  import sphere_loader_pkg::*;
#(
  parameter int unsigned MaxSpheres = MAX_SPHERES_DEF,
  parameter int unsigned IdxB       = $clog2(MaxSpheres)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  sphere_loader_if.slave  in_if,
  input  logic            frame_end_i,
  input  logic [IdxB-1:0] rd_idx_i,
  output sphere_t         rd_sphere_o,
  output logic [IdxB:0]   active_count_o,
  output logic            load_busy_o,
  output logic            overflow_err_o
);

  localparam logic [IdxB:0] MaxCnt = (IdxB+1)'(MaxSpheres);

  loader_state_e state_q;
  logic          front_sel_q;
  logic [2:0]    byte_cnt_q;
  logic [7:0]    entry_cnt_q;
  logic [7:0]    hdr_n_q;
  logic [IdxB:0] back_cnt_q;
  logic [IdxB:0] active_cnt_q;
  logic          overflow_q;
  logic          busy_q;
  logic          in_ready_q;
  // Only seven bytes are buffered; the eighth goes straight to the table.
  logic [55:0]   asm_q;

  logic            accept;
  logic            hdr_ovf;
  logic [IdxB:0]   hdr_cnt;
  logic            rec_done;
  logic            tbl_we;
  logic [IdxB-1:0] tbl_waddr;
  sphere_t         tbl_wdata;

  always_comb begin
    accept    = in_if.in_valid && in_ready_q;
    hdr_ovf   = 32'(in_if.in_data) > MaxSpheres;
    hdr_cnt   = hdr_ovf ? MaxCnt : (IdxB+1)'(in_if.in_data);
    rec_done  = (state_q == S_LOAD) && accept && (byte_cnt_q == 3'd7);
    // Records past the table size are consumed but never written.
    tbl_we    = rec_done && (32'(entry_cnt_q) < MaxSpheres);
    tbl_waddr = entry_cnt_q[IdxB-1:0];
    tbl_wdata = pack_sphere(asm_q, in_if.in_data);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      front_sel_q  <= 1'b0;
      byte_cnt_q   <= '0;
      entry_cnt_q  <= '0;
      hdr_n_q      <= '0;
      back_cnt_q   <= '0;
      active_cnt_q <= '0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b1;
      asm_q        <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            hdr_n_q     <= in_if.in_data;
            byte_cnt_q  <= '0;
            entry_cnt_q <= '0;
            busy_q      <= 1'b1;
            back_cnt_q  <= hdr_cnt;
            if (in_if.in_data == 8'd0) begin
              state_q    <= S_SWAP_WAIT;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= S_LOAD;
              if (hdr_ovf) begin
                overflow_q <= 1'b1;
              end
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            asm_q      <= {asm_q[47:0], in_if.in_data};
            byte_cnt_q <= byte_cnt_q + 3'd1;
            if (byte_cnt_q == 3'd7) begin
              entry_cnt_q <= entry_cnt_q + 8'd1;
              if (entry_cnt_q == hdr_n_q - 8'd1) begin
                state_q    <= S_SWAP_WAIT;
                in_ready_q <= 1'b0;
              end
            end
          end
        end
        S_SWAP_WAIT: begin
          if (frame_end_i) begin
            front_sel_q  <= ~front_sel_q;
            active_cnt_q <= back_cnt_q;
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // Back buffer is always the opposite bank; reads in the swap cycle still see the old front.
  sphere_table_dp #(
    .MaxSpheres (MaxSpheres),
    .IdxB       (IdxB)
  ) u_table (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .we_i      (tbl_we),
    .wr_bank_i (~front_sel_q),
    .wr_addr_i (tbl_waddr),
    .wr_data_i (tbl_wdata),
    .rd_bank_i (front_sel_q),
    .rd_addr_i (rd_idx_i),
    .rd_data_o (rd_sphere_o)
  );

  assign in_if.in_ready = in_ready_q;
  assign active_count_o = active_cnt_q;
  assign load_busy_o    = busy_q;
  assign overflow_err_o = overflow_q;

endmodule

// File: tb/tb_sphere_loader.sv
module tb_sphere_loader;
  import sphere_loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_end = 1'b0;
  logic [2:0] rd_idx = '0;
  sphere_t    rd_sphere;
  logic [3:0] active_count;
  logic       load_busy;
  logic       overflow_err;

  sphere_loader_if bus ();

  sphere_loader #(.MaxSpheres(8), .IdxB(3)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_if          (bus),
    .frame_end_i    (frame_end),
    .rd_idx_i       (rd_idx),
    .rd_sphere_o    (rd_sphere),
    .active_count_o (active_count),
    .load_busy_o    (load_busy),
    .overflow_err_o (overflow_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];

  typedef struct {
    int hdr;
    int scene;
    int gap_len;
    int exp_active;
    bit exp_ovf;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [63:0] rec(input int s, input int i);
    logic [31:0] lo;
    if (s == 0 && i == 0) return 64'h0123456789ABCDEF;
    lo = 32'h9E37_79B9 * 32'(s * 16 + i + 1);
    return {8'hF0, 8'(s), 8'(i), 8'(s ^ i), lo};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b);
    int w;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("in_ready timeout", 64'd0, 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rec(input logic [63:0] r);
    for (int k = 7; k >= 0; k--) send_byte(r[k*8 +: 8]);
  endtask

  task automatic load_scene(input int s, input int n);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) send_rec(rec(s, i));
  endtask

  task automatic pulse_fe;
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  task automatic read_chk(input string name, input int idx, input logic [63:0] exp);
    rd_idx = 3'(idx);
    exp_q.push_back(exp);
    @(negedge clk);
    chk(name, rd_sphere, exp_q.pop_front());
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    frame_end = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " active_count"}, 64'(active_count), 64'd0);
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, " load_busy"}, 64'(load_busy), 64'd0);
    chk({tag, " overflow_err"}, 64'(overflow_err), 64'd0);
    chk({tag, " rd_sphere"}, rd_sphere, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{hdr: 1,  scene: 0, gap_len: 0, exp_active: 1, exp_ovf: 1'b0};
    vecs[1] = '{hdr: 3,  scene: 1, gap_len: 5, exp_active: 3, exp_ovf: 1'b0};
    vecs[2] = '{hdr: 8,  scene: 2, gap_len: 0, exp_active: 8, exp_ovf: 1'b0};
    vecs[3] = '{hdr: 10, scene: 3, gap_len: 0, exp_active: 8, exp_ovf: 1'b1};
    vecs[4] = '{hdr: 0,  scene: 4, gap_len: 0, exp_active: 0, exp_ovf: 1'b0};
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    @(negedge clk);

    // Table-driven scene loads
    for (int v = 0; v < 5; v++) begin
      logic [63:0] r;
      do_reset();
      check_idle($sformatf("v%0d reset", v));
      send_byte(8'(vecs[v].hdr));
      chk($sformatf("v%0d busy after header", v), 64'(load_busy), 64'd1);
      for (int i = 0; i < vecs[v].hdr; i++) begin
        r = rec(vecs[v].scene, i);
        for (int k = 7; k >= 0; k--) begin
          if (vecs[v].gap_len > 0 && i == 1 && k == 4) begin
            bus.in_valid = 1'b0;
            repeat (vecs[v].gap_len) @(negedge clk);
          end
          send_byte(r[k*8 +: 8]);
        end
      end
      chk($sformatf("v%0d in_ready in swap wait", v), 64'(bus.in_ready), 64'd0);
      // Valid held high while the back buffer is locked must not be accepted.
      bus.in_data  = 8'h55;
      bus.in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk($sformatf("v%0d in_ready held low", v), 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d no swap yet", v), 64'(active_count), 64'd0);
      pulse_fe();
      chk($sformatf("v%0d active_count", v), 64'(active_count), 64'(vecs[v].exp_active));
      chk($sformatf("v%0d overflow_err", v), 64'(overflow_err), 64'(vecs[v].exp_ovf));
      chk($sformatf("v%0d busy after swap", v), 64'(load_busy), 64'd0);
      chk($sformatf("v%0d in_ready after swap", v), 64'(bus.in_ready), 64'd1);
      for (int j = 0; j < vecs[v].exp_active; j++)
        read_chk($sformatf("v%0d entry %0d", v, j), j, rec(vecs[v].scene, j));
    end

    // Scene B loads while entry 1 of scene A is read continuously
    begin
      logic [63:0] rb;
      do_reset();
      load_scene(20, 2);
      pulse_fe();
      chk("ab active A", 64'(active_count), 64'd2);
      rd_idx = 3'd1;
      @(negedge clk);
      chk("ab read A1", rd_sphere, rec(20, 1));
      send_byte(8'd1);
      rb = rec(21, 0);
      for (int k = 7; k >= 0; k--) begin
        send_byte(rb[k*8 +: 8]);
        chk("ab A1 during load", rd_sphere, rec(20, 1));
      end
      pulse_fe();
      chk("ab swap-cycle read old", rd_sphere, rec(20, 1));
      chk("ab active B", 64'(active_count), 64'd1);
      read_chk("ab B0", 0, rec(21, 0));
    end

    // frame_end on the final record byte does not swap
    begin
      logic [63:0] rl;
      load_scene(30, 1);
      pulse_fe();
      chk("fe active before", 64'(active_count), 64'd1);
      send_byte(8'd2);
      send_rec(rec(31, 0));
      rl = rec(31, 1);
      for (int k = 7; k >= 1; k--) send_byte(rl[k*8 +: 8]);
      frame_end = 1'b1;
      send_byte(rl[7:0]);
      frame_end = 1'b0;
      chk("fe no swap", 64'(active_count), 64'd1);
      chk("fe in swap wait", 64'(bus.in_ready), 64'd0);
      repeat (3) @(negedge clk);
      chk("fe still no swap", 64'(active_count), 64'd1);
      pulse_fe();
      chk("fe swapped", 64'(active_count), 64'd2);
      read_chk("fe entry 1", 1, rec(31, 1));
    end

    // Reset during byte 4 of a record
    begin
      logic [63:0] rr;
      rr = rec(40, 0);
      send_byte(8'd1);
      for (int k = 7; k >= 5; k--) send_byte(rr[k*8 +: 8]);
      bus.in_data  = rr[39:32];
      bus.in_valid = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      check_idle("midrst");
      load_scene(41, 1);
      pulse_fe();
      chk("midrst reload active", 64'(active_count), 64'd1);
      read_chk("midrst reload entry 0", 0, rec(41, 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sphere_loader.md
Name: sphere_loader

Overview:
- Receives the scene description as a byte stream from the host-link receiver and assembles it into 64-bit Sphere records: x 16b, y 15b, z 15b signed 3-fraction-bit fixed point, r 6b, c 12b.
- Stores the records in a double-buffered sphere table.
- Feeds the per-pixel ray/sphere intersection stage, which reads the front buffer at random.
- The buffer swap happens only at a frame boundary signalled by the renderer, so a frame never mixes two scenes.

Parameters:
- MAX_SPHERES, 8, number of entries per buffer; must be a power of two, at least 2.
- IDX_B, $clog2(MAX_SPHERES), width of the read index.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_data  in  8  scene byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid and in_ready are both high
- frame_end  in  1  one-cycle pulse from the renderer after the last pixel of a frame
- rd_idx  in  IDX_B  front-buffer entry to read
- rd_sphere  out  64  Types::Sphere at rd_idx, registered
- active_count  out  IDX_B+1  number of valid spheres in the front buffer
- load_busy  out  1  high whenever the state is not S_IDLE
- overflow_err  out  1  sticky; the header count exceeded MAX_SPHERES

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (clk, rst). Reset forces:
  - state S_IDLE, front-buffer select 0, byte/entry counters 0
  - active_count 0, back count 0, rd_sphere 0
  - overflow_err 0, load_busy 0, in_ready 1
  - Table RAM contents are not reset.
- Stream format: byte 0 is the header N (unsigned 8b sphere count), followed by N×8 record bytes. Each record is sent MSB first: the first byte is packed bits [63:56], i.e. x[15:8]; the last byte is bits [7:0], i.e. c[7:0].
- States:
  - S_IDLE: in_ready=1. An accepted byte latches N.
    - N=0: go to S_SWAP_WAIT with back count 0.
    - Otherwise: back count = min(N, MAX_SPHERES); overflow_err sets if N > MAX_SPHERES; go to S_LOAD.
  - S_LOAD: in_ready=1. Each accepted byte shifts into a 64b assembly register and increments a 3b byte counter.
    - On the 8th byte, write the completed record to back[entry] only if entry < MAX_SPHERES. Records beyond MAX_SPHERES are consumed and discarded.
    - After record N, go to S_SWAP_WAIT.
  - S_SWAP_WAIT: in_ready=0 (back-pressure: the back buffer is locked).
    - On frame_end: toggle the buffer select, active_count <= back count, go to S_IDLE.
- frame_end outside S_SWAP_WAIT is ignored.
- Timing corner: a frame_end in the same cycle as the final record byte does not swap. The state enters S_SWAP_WAIT on the next edge, and the swap waits for the next frame_end.
- Read port: rd_sphere <= front[rd_idx] each cycle, 1-cycle latency.
  - rd_idx >= active_count returns stale data. The consumer must gate with active_count.
  - The read issued in the swap cycle returns the old front entry; reads issued from the next cycle return the new front.
- in_valid low mid-record: hold all counters; there is no timeout.
- Reset mid-load: the partial record is discarded, the front buffer reverts to select 0, and active_count is 0.
- overflow_err is cleared only by rst.

Decomposition:
- Types package additions:
  - `define SPHERE_B 64
  - `define MAX_SPHERES_DEF 8
  - typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SWAP_WAIT} LoaderState
- Assembly register and counters stay in sphere_loader.
- One sub-module: sphere_table_dp.
  - Two banks of MAX_SPHERES × Types::Sphere, inferred block/distributed RAM.
  - Write port: bank, addr, data, we.
  - Registered read port: bank, addr.

Test Plan:
- Load 1 sphere, bytes 01 01 23 45 67 89 AB CD EF, then pulse frame_end.
  - Expect: active_count=1; rd_idx=0 → rd_sphere=64'h0123456789ABCDEF one cycle later; overflow_err=0.
- Header 03 plus 24 bytes, with in_valid deasserted for 5 cycles mid-record 2.
  - Expect: all 3 records intact.
  - Expect: in_ready=0 from the cycle after the last byte until frame_end.
  - Expect: in_valid held high during S_SWAP_WAIT accepts nothing.
- Header 0A (10) with MAX_SPHERES=8, 80 bytes sent.
  - Expect: all 80 accepted; overflow_err=1; active_count=8 after swap.
  - Expect: entry 7 = record 8; records 9–10 absent.
- Scene A (2 spheres) active; load scene B (1 sphere) while reading entry 1 continuously.
  - Expect: rd_sphere = A[1] until the swap cycle; after swap, active_count=1 and entry 0 = B[0].
- frame_end pulsed in the same cycle as the final record byte.
  - Expect: no swap; active_count unchanged.
  - Expect: the swap occurs on the following frame_end pulse.
- Header 00, then frame_end.
  - Expect: active_count=0.
- rst asserted during byte 4 of a record.
  - Expect: next cycle active_count=0, in_ready=1, load_busy=0.
  - Expect: a fresh 1-sphere load then succeeds.
